// File: rtl/core_pkg.sv
// core_pkg: shared physical-register sizing and tag type
package core_pkg;
  localparam int NUM_PREGS = 128;
  localparam int NUM_ARCH = 32;
  localparam int TAG_W = $clog2(NUM_PREGS);
  typedef logic [TAG_W-1:0] preg_t;
endpackage

// File: rtl/free_list_mp_prefix_popcount.sv
// prefix_popcount: per-bit count of set bits below each position, plus total
module prefix_popcount #(
  parameter int N = 2,
  parameter int CW = 8
) (
  input  logic [N-1:0]         bits,
  output logic [N-1:0][CW-1:0] offs,
  output logic [CW-1:0]        total
);
  // running sum: each port's offset is the count before it
  always_comb begin
    total = '0;
    for (int i = 0; i < N; i++) begin
      offs[i] = total;
      total = total + CW'(bits[i]);
    end
  end
endmodule

// File: rtl/free_list_mp.sv
// free_list_mp: multi-port circular free list of physical register tags with branch checkpoints
module free_list_mp
  import core_pkg::*;
#(
  parameter int NUM_PREGS = core_pkg::NUM_PREGS,
  parameter int NUM_ARCH = core_pkg::NUM_ARCH,
  parameter int ALLOC_W = 2,
  parameter int FREE_W = 2,
  parameter int NUM_CKPT = 4,
  parameter int TAG_W = $clog2(NUM_PREGS),
  parameter int CNT_W = TAG_W + 1,
  parameter int CK_W = $clog2(NUM_CKPT)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [ALLOC_W-1:0]             alloc_req,
  output logic                           alloc_grant,
  output logic [ALLOC_W-1:0][TAG_W-1:0]  alloc_preg,
  input  logic [FREE_W-1:0]              free_vld,
  input  logic [FREE_W-1:0][TAG_W-1:0]   free_preg,
  input  logic                           ckpt_save,
  input  logic [CK_W-1:0]                ckpt_save_id,
  input  logic                           ckpt_restore,
  input  logic [CK_W-1:0]                ckpt_restore_id,
  output logic [CNT_W-1:0]               free_count,
  output logic                           empty,
  output logic                           err_overflow
);
  logic [TAG_W-1:0] mem [NUM_PREGS];
  logic [CNT_W-1:0] r_ptr, w_ptr, r_nxt, w_adv, room;
  logic [CNT_W-1:0] ckpt [NUM_CKPT];
  logic [ALLOC_W-1:0][CNT_W-1:0] a_off;
  logic [FREE_W-1:0][CNT_W-1:0] f_off;
  logic [CNT_W-1:0] a_total, f_total;
  logic [FREE_W-1:0] f_wr;
  logic [FREE_W-1:0][TAG_W-1:0] f_idx;
  logic f_over;

  prefix_popcount #(.N(ALLOC_W), .CW(CNT_W)) u_alloc_cnt (
    .bits(alloc_req), .offs(a_off), .total(a_total)
  );

  prefix_popcount #(.N(FREE_W), .CW(CNT_W)) u_free_cnt (
    .bits(free_vld), .offs(f_off), .total(f_total)
  );

  assign free_count = w_ptr - r_ptr;
  assign empty = (w_ptr == r_ptr);
  assign room = CNT_W'(NUM_PREGS) - free_count;
  assign f_over = f_total > room;
  assign w_adv = f_over ? room : f_total;

  // all-or-nothing grant against registered occupancy; restore blocks allocation
  always_comb begin
    alloc_grant = (a_total <= free_count) && !ckpt_restore;
    for (int i = 0; i < ALLOC_W; i++)
      alloc_preg[i] = mem[TAG_W'(r_ptr + a_off[i])];
    r_nxt = ckpt_restore ? ckpt[ckpt_restore_id] : alloc_grant ? r_ptr + a_total : r_ptr;
  end

  // compacted free slots; ports past the remaining room are dropped
  always_comb begin
    for (int i = 0; i < FREE_W; i++) begin
      f_idx[i] = TAG_W'(w_ptr + f_off[i]);
      f_wr[i] = free_vld[i] && (f_off[i] < room);
    end
  end

  // pointer, tag array, checkpoint and error state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr <= '0;
      w_ptr <= CNT_W'(NUM_PREGS - NUM_ARCH);
      err_overflow <= 1'b0;
      for (int i = 0; i < NUM_PREGS; i++)
        mem[i] <= (i < NUM_PREGS - NUM_ARCH) ? TAG_W'(NUM_ARCH + i) : '0;
      for (int i = 0; i < NUM_CKPT; i++)
        ckpt[i] <= '0;
    end else begin
      r_ptr <= r_nxt;
      w_ptr <= w_ptr + w_adv;
      if (f_over)
        err_overflow <= 1'b1;
      for (int i = 0; i < FREE_W; i++)
        if (f_wr[i])
          mem[f_idx[i]] <= free_preg[i];
      if (ckpt_save && !ckpt_restore)
        ckpt[ckpt_save_id] <= r_nxt;
    end
  end
endmodule

// File: tb/tb_free_list_mp.sv
// tb_free_list_mp: directed stimulus with a queued-expectation scoreboard for free_list_mp
module tb_free_list_mp;
  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] alloc_req;
  logic alloc_grant;
  logic [1:0][6:0] alloc_preg;
  logic [1:0] free_vld;
  logic [1:0][6:0] free_preg;
  logic ckpt_save, ckpt_restore;
  logic [1:0] ckpt_save_id, ckpt_restore_id;
  logic [7:0] free_count;
  logic empty, err_overflow;
  typedef struct {int kind; int val;} exp_t;
  exp_t q[$];
  exp_t e;
  int n_vec = 0;
  int n_bad = 0;
  int act;
  string nm[6] = '{"free_count", "empty", "alloc_grant", "alloc_preg0", "alloc_preg1", "err_overflow"};
  always #5 clk = ~clk;
  free_list_mp dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_req(alloc_req), .alloc_grant(alloc_grant), .alloc_preg(alloc_preg),
    .free_vld(free_vld), .free_preg(free_preg),
    .ckpt_save(ckpt_save), .ckpt_save_id(ckpt_save_id),
    .ckpt_restore(ckpt_restore), .ckpt_restore_id(ckpt_restore_id),
    .free_count(free_count), .empty(empty), .err_overflow(err_overflow)
  );
  function automatic int sel(input int k);
    case (k)
      0: sel = int'(free_count);
      1: sel = int'(empty);
      2: sel = int'(alloc_grant);
      3: sel = int'(alloc_preg[0]);
      4: sel = int'(alloc_preg[1]);
      default: sel = int'(err_overflow);
    endcase
  endfunction
  always @(negedge clk) begin
    while (q.size() > 0) begin
      e = q.pop_front();
      act = sel(e.kind);
      n_vec++;
      if (act != e.val) begin
        n_bad++;
        $display("FAIL %s: got %0d, want %0d", nm[e.kind], act, e.val);
      end
    end
  end
  initial begin
    #50000;
    n_bad++;
    $display("FAIL timeout: stimulus did not complete");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
  task automatic chk(input int k, input int v);
    exp_t x;
    x.kind = k;
    x.val = v;
    q.push_back(x);
  endtask
  task automatic drive(input logic [1:0] ar, input logic [1:0] fv, input int f0, input int f1);
    alloc_req = ar;
    free_vld = fv;
    free_preg[0] = 7'(f0);
    free_preg[1] = 7'(f1);
    ckpt_save = 1'b0;
    ckpt_restore = 1'b0;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst_n = 1'b0;
    ckpt_save_id = 2'd0;
    ckpt_restore_id = 2'd0;
    drive(2'b00, 2'b00, 0, 0);
    step();
    step();
    n_vec++;
    if (free_count != 8'd96 || empty !== 1'b0) begin
      n_bad++;
      $display("FAIL reset state: free_count=%0d empty=%0d", free_count, empty);
    end
    rst_n = 1'b1;
    drive(2'b11, 2'b00, 0, 0);
    chk(0, 96); chk(1, 0); chk(5, 0); chk(2, 1); chk(3, 32); chk(4, 33);
    step();
    for (int k = 1; k < 5; k++) begin
      drive(2'b11, 2'b00, 0, 0);
      chk(2, 1); chk(3, 32 + 2 * k); chk(4, 33 + 2 * k);
      step();
    end
    drive(2'b00, 2'b00, 0, 0);
    ckpt_save = 1'b1;
    ckpt_save_id = 2'd2;
    chk(0, 86);
    step();
    for (int k = 0; k < 3; k++) begin
      drive(2'b11, 2'b00, 0, 0);
      chk(2, 1); chk(3, 42 + 2 * k); chk(4, 43 + 2 * k);
      step();
    end
    drive(2'b11, 2'b00, 0, 0);
    ckpt_restore = 1'b1;
    ckpt_restore_id = 2'd2;
    chk(0, 80); chk(2, 0);
    step();
    for (int k = 0; k < 43; k++) begin
      drive(2'b11, 2'b00, 0, 0);
      if (k == 0) chk(0, 86);
      chk(2, 1); chk(3, 42 + 2 * k); chk(4, 43 + 2 * k);
      step();
    end
    drive(2'b11, 2'b00, 0, 0);
    chk(0, 0); chk(1, 1); chk(2, 0);
    step();
    drive(2'b00, 2'b01, 5, 0);
    chk(0, 0); chk(1, 1);
    step();
    drive(2'b11, 2'b00, 0, 0);
    chk(0, 1); chk(2, 0);
    step();
    drive(2'b10, 2'b00, 0, 0);
    chk(0, 1); chk(2, 1); chk(4, 5);
    step();
    chk(0, 0); chk(1, 1);
    for (int j = 0; j < 15; j++) begin
      drive(2'b00, 2'b11, 50 + 2 * j, 51 + 2 * j);
      step();
    end
    chk(0, 30);
    for (int k = 0; k < 12; k++) begin
      drive(2'b11, 2'b00, 0, 0);
      chk(2, 1); chk(3, 50 + 2 * k); chk(4, 51 + 2 * k);
      step();
    end
    drive(2'b01, 2'b00, 0, 0);
    chk(0, 6); chk(2, 1); chk(3, 74);
    step();
    drive(2'b11, 2'b11, 7, 9);
    chk(0, 5); chk(2, 1); chk(3, 75); chk(4, 76);
    step();
    drive(2'b11, 2'b00, 0, 0);
    chk(0, 5); chk(2, 1); chk(3, 77); chk(4, 78);
    step();
    drive(2'b11, 2'b00, 0, 0);
    chk(2, 1); chk(3, 79); chk(4, 7);
    step();
    drive(2'b01, 2'b00, 0, 0);
    chk(2, 1); chk(3, 9);
    step();
    drive(2'b00, 2'b00, 0, 0);
    chk(0, 0); chk(1, 1); chk(5, 0);
    step();
    for (int i = 0; i < 64; i++) begin
      drive(2'b00, 2'b11, i, 127 - i);
      step();
    end
    drive(2'b00, 2'b01, 3, 0);
    chk(0, 128); chk(1, 0); chk(5, 0);
    step();
    drive(2'b00, 2'b00, 0, 0);
    chk(0, 128); chk(5, 1);
    step();
    chk(0, 128); chk(5, 1);
    step();
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
